// File: rtl/expmul_job_sequencer_if.sv
// AXI4-Lite bus between the job sequencer (master) and the exponent/multiplier slave.
interface expmul_job_sequencer_if;
  logic [31:0] M_AXI_AWADDR;
  logic        M_AXI_AWVALID;
  logic        M_AXI_AWREADY;
  logic [31:0] M_AXI_WDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_WVALID;
  logic        M_AXI_WREADY;
  logic [1:0]  M_AXI_BRESP;
  logic        M_AXI_BVALID;
  logic        M_AXI_BREADY;
  logic [31:0] M_AXI_ARADDR;
  logic        M_AXI_ARVALID;
  logic        M_AXI_ARREADY;
  logic [31:0] M_AXI_RDATA;
  logic [1:0]  M_AXI_RRESP;
  logic        M_AXI_RVALID;
  logic        M_AXI_RREADY;

  modport master (
    output M_AXI_AWADDR, M_AXI_AWVALID, input M_AXI_AWREADY,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, input M_AXI_WREADY,
    input M_AXI_BRESP, M_AXI_BVALID, output M_AXI_BREADY,
    output M_AXI_ARADDR, M_AXI_ARVALID, input M_AXI_ARREADY,
    input M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID, output M_AXI_RREADY
  );

  modport slave (
    input M_AXI_AWADDR, M_AXI_AWVALID, output M_AXI_AWREADY,
    input M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, output M_AXI_WREADY,
    output M_AXI_BRESP, M_AXI_BVALID, input M_AXI_BREADY,
    input M_AXI_ARADDR, M_AXI_ARVALID, output M_AXI_ARREADY,
    output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID, input M_AXI_RREADY
  );
endinterface

// File: rtl/expmul_job_sequencer.sv
// AXI4-Lite master running one multiply/exponent job: writes A, B, SELECT, START,
// polls DONE with a bounded retry count, reads P and returns it on a valid/ready port.
module expmul_job_sequencer #(
  parameter logic [31:0] BASE_ADDR  = 32'h7C80_0000,
  parameter int unsigned POLL_LIMIT = 64
) (
  input  logic        S_AXI_ACLK,
  input  logic        S_AXI_ARESETN,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [31:0] job_a,
  input  logic [31:0] job_b,
  input  logic        job_sel,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        res_timeout,
  output logic        res_err,
  output logic        busy,
  expmul_job_sequencer_if.master m_axi
);

  localparam logic [31:0] OFF_A     = 32'h00;
  localparam logic [31:0] OFF_B     = 32'h04;
  localparam logic [31:0] OFF_SEL   = 32'h08;
  localparam logic [31:0] OFF_START = 32'h0C;
  localparam logic [31:0] OFF_P     = 32'h10;
  localparam logic [31:0] OFF_DONE  = 32'h14;
  localparam logic [7:0]  POLL_MAX  = 8'(POLL_LIMIT);

  typedef enum logic [2:0] {
    IDLE, WR_A, WR_B, WR_SEL, WR_START, RD_DONE, RD_P, RESP
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic        sel_q, sel_d;
  logic        err_q, err_d;
  logic [7:0]  poll_q, poll_d;
  logic [31:0] res_data_q, res_data_d;
  logic        res_to_q, res_to_d;
  logic        awvalid_q, awvalid_d, aw_done_q, aw_done_d;
  logic        wvalid_q, wvalid_d, w_done_q, w_done_d;
  logic        bready_q, bready_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic        aw_hs, w_hs;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      sel_q      <= 1'b0;
      err_q      <= 1'b0;
      poll_q     <= '0;
      res_data_q <= '0;
      res_to_q   <= 1'b0;
      awvalid_q  <= 1'b0;
      aw_done_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      w_done_q   <= 1'b0;
      bready_q   <= 1'b0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sel_q      <= sel_d;
      err_q      <= err_d;
      poll_q     <= poll_d;
      res_data_q <= res_data_d;
      res_to_q   <= res_to_d;
      awvalid_q  <= awvalid_d;
      aw_done_q  <= aw_done_d;
      wvalid_q   <= wvalid_d;
      w_done_q   <= w_done_d;
      bready_q   <= bready_d;
      arvalid_q  <= arvalid_d;
      rready_q   <= rready_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    sel_d      = sel_q;
    err_d      = err_q;
    poll_d     = poll_q;
    res_data_d = res_data_q;
    res_to_d   = res_to_q;
    awvalid_d  = awvalid_q;
    aw_done_d  = aw_done_q;
    wvalid_d   = wvalid_q;
    w_done_d   = w_done_q;
    bready_d   = bready_q;
    arvalid_d  = arvalid_q;
    rready_d   = rready_q;
    aw_hs      = awvalid_q && m_axi.M_AXI_AWREADY;
    w_hs       = wvalid_q && m_axi.M_AXI_WREADY;

    unique case (state_q)
      IDLE: begin
        if (job_valid) begin
          a_d        = job_a;
          b_d        = job_b;
          sel_d      = job_sel;
          err_d      = 1'b0;
          poll_d     = '0;
          res_data_d = '0;
          res_to_d   = 1'b0;
          awvalid_d  = 1'b1;
          wvalid_d   = 1'b1;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          state_d    = WR_A;
        end
      end

      // Address and data channels complete independently; BREADY follows once both have.
      WR_A, WR_B, WR_SEL, WR_START: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if (!bready_q && (aw_done_q || aw_hs) && (w_done_q || w_hs)) bready_d = 1'b1;
        if (bready_q && m_axi.M_AXI_BVALID) begin
          bready_d = 1'b0;
          err_d    = err_q | (m_axi.M_AXI_BRESP != 2'b00);
          if (state_q == WR_START) begin
            arvalid_d = 1'b1;
            state_d   = RD_DONE;
          end else begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = (state_q == WR_A) ? WR_B : (state_q == WR_B) ? WR_SEL : WR_START;
          end
        end
      end

      RD_DONE, RD_P: begin
        if (arvalid_q && m_axi.M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
        if (rready_q && m_axi.M_AXI_RVALID) begin
          rready_d = 1'b0;
          err_d    = err_q | (m_axi.M_AXI_RRESP != 2'b00);
          if (state_q == RD_P) begin
            res_data_d = m_axi.M_AXI_RDATA;
            state_d    = RESP;
          end else if (m_axi.M_AXI_RDATA[0]) begin
            arvalid_d = 1'b1;
            state_d   = RD_P;
          end else begin
            poll_d = poll_q + 8'd1;
            if ((poll_q + 8'd1) == POLL_MAX) begin
              res_to_d   = 1'b1;
              res_data_d = '0;
              state_d    = RESP;
            end else begin
              arvalid_d = 1'b1;
            end
          end
        end
      end

      RESP: begin
        if (res_ready) state_d = IDLE;
      end
    endcase
  end

  // Address/data buses are decoded from the state so they stay stable for a whole transfer.
  always_comb begin
    m_axi.M_AXI_AWADDR = '0;
    m_axi.M_AXI_WDATA  = '0;
    m_axi.M_AXI_WSTRB  = '0;
    m_axi.M_AXI_ARADDR = '0;
    unique case (state_q)
      WR_A: begin
        m_axi.M_AXI_AWADDR = BASE_ADDR + OFF_A;
        m_axi.M_AXI_WDATA  = a_q;
        m_axi.M_AXI_WSTRB  = 4'hF;
      end
      WR_B: begin
        m_axi.M_AXI_AWADDR = BASE_ADDR + OFF_B;
        m_axi.M_AXI_WDATA  = b_q;
        m_axi.M_AXI_WSTRB  = 4'hF;
      end
      WR_SEL: begin
        m_axi.M_AXI_AWADDR = BASE_ADDR + OFF_SEL;
        m_axi.M_AXI_WDATA  = {31'b0, sel_q};
        m_axi.M_AXI_WSTRB  = 4'hF;
      end
      WR_START: begin
        m_axi.M_AXI_AWADDR = BASE_ADDR + OFF_START;
        m_axi.M_AXI_WDATA  = 32'd1;
        m_axi.M_AXI_WSTRB  = 4'hF;
      end
      RD_DONE: m_axi.M_AXI_ARADDR = BASE_ADDR + OFF_DONE;
      RD_P:    m_axi.M_AXI_ARADDR = BASE_ADDR + OFF_P;
      default: ;
    endcase
  end

  assign m_axi.M_AXI_AWVALID = awvalid_q;
  assign m_axi.M_AXI_WVALID  = wvalid_q;
  assign m_axi.M_AXI_BREADY  = bready_q;
  assign m_axi.M_AXI_ARVALID = arvalid_q;
  assign m_axi.M_AXI_RREADY  = rready_q;

  assign job_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign res_valid   = (state_q == RESP);
  assign res_data    = res_data_q;
  assign res_timeout = res_to_q;
  assign res_err     = err_q;

endmodule

// File: tb/tb_expmul_job_sequencer.sv
// Directed bench for expmul_job_sequencer against a small behavioural AXI4-Lite
// model of the exponent/multiplier slave.
module tb_expmul_job_sequencer;
  localparam logic [31:0] BASE = 32'h7C80_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        job_valid = 1'b0, job_ready, job_sel = 1'b0;
  logic [31:0] job_a = '0, job_b = '0;
  logic        res_valid, res_ready = 1'b0, res_timeout, res_err, busy;
  logic [31:0] res_data;

  expmul_job_sequencer_if axi ();

  expmul_job_sequencer #(.BASE_ADDR(BASE), .POLL_LIMIT(4)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_a(job_a), .job_b(job_b), .job_sel(job_sel),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_timeout(res_timeout), .res_err(res_err), .busy(busy),
    .m_axi(axi)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0, n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- slave model ----------------
  logic [31:0] stall_addr = 32'hFFFF_FFFF;
  int unsigned stall_n = 0;
  logic [31:0] err_addr = 32'hFFFF_FFFF;
  int unsigned done_delay = 2;

  int unsigned aw_wait, dcnt;
  logic [31:0] r_a, r_b, r_sel;
  logic        aw_got, w_got, bvalid, rvalid;
  logic [31:0] aw_addr_p, w_data_p, rdata;
  logic [1:0]  bresp;
  logic [31:0] wr_addr_log[$], wr_data_log[$], rd_addr_log[$];

  function automatic logic [31:0] ipow(input logic [31:0] base, input logic [31:0] e);
    logic [31:0] r = 32'd1;
    for (int unsigned i = 0; i < e && i < 64; i++) r = r * base;
    return r;
  endfunction

  assign axi.M_AXI_AWREADY = !(axi.M_AXI_AWADDR == stall_addr && aw_wait < stall_n);
  assign axi.M_AXI_WREADY  = 1'b1;
  assign axi.M_AXI_ARREADY = 1'b1;
  assign axi.M_AXI_BVALID  = bvalid;
  assign axi.M_AXI_BRESP   = bresp;
  assign axi.M_AXI_RVALID  = rvalid;
  assign axi.M_AXI_RDATA   = rdata;
  assign axi.M_AXI_RRESP   = 2'b00;

  always @(posedge clk or negedge rst_n) begin : slave
    logic ha, hw;
    logic [31:0] wa, wd;
    if (!rst_n) begin
      aw_got <= 1'b0; w_got <= 1'b0; bvalid <= 1'b0; rvalid <= 1'b0;
      aw_wait <= 0; dcnt <= 0; bresp <= 2'b00; rdata <= '0;
    end else begin
      ha = aw_got || (axi.M_AXI_AWVALID && axi.M_AXI_AWREADY);
      hw = w_got || (axi.M_AXI_WVALID && axi.M_AXI_WREADY);
      wa = aw_got ? aw_addr_p : axi.M_AXI_AWADDR;
      wd = w_got ? w_data_p : axi.M_AXI_WDATA;
      aw_wait <= (axi.M_AXI_AWVALID && !axi.M_AXI_AWREADY) ? aw_wait + 1 : 0;
      if (bvalid && axi.M_AXI_BREADY) bvalid <= 1'b0;
      if (ha && hw && !bvalid) begin
        bvalid <= 1'b1;
        bresp  <= (wa == err_addr) ? 2'b10 : 2'b00;
        wr_addr_log.push_back(wa);
        wr_data_log.push_back(wd);
        if (wa == BASE)          r_a   <= wd;
        if (wa == BASE + 32'h04) r_b   <= wd;
        if (wa == BASE + 32'h08) r_sel <= wd;
        if (wa == BASE + 32'h0C) dcnt  <= 0;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end else begin
        if (axi.M_AXI_AWVALID && axi.M_AXI_AWREADY) begin aw_got <= 1'b1; aw_addr_p <= axi.M_AXI_AWADDR; end
        if (axi.M_AXI_WVALID && axi.M_AXI_WREADY) begin w_got <= 1'b1; w_data_p <= axi.M_AXI_WDATA; end
      end
      if (rvalid && axi.M_AXI_RREADY) rvalid <= 1'b0;
      if (axi.M_AXI_ARVALID && axi.M_AXI_ARREADY) begin
        rvalid <= 1'b1;
        rd_addr_log.push_back(axi.M_AXI_ARADDR);
        if (axi.M_AXI_ARADDR == BASE + 32'h14) begin
          rdata <= (dcnt >= done_delay) ? 32'd1 : 32'd0;
          dcnt  <= dcnt + 1;
        end else if (axi.M_AXI_ARADDR == BASE + 32'h10) begin
          rdata <= r_sel[0] ? ipow(r_a, r_b) : r_a * r_b;
        end else begin
          rdata <= 32'hDEAD_BEEF;
        end
      end
    end
  end

  // ---------------- protocol monitor ----------------
  int unsigned aw_b_cyc = 0, w_b_cyc = 0, viol = 0, strb_bad = 0;
  always @(posedge clk) begin
    if (rst_n) begin
      if (axi.M_AXI_AWVALID && axi.M_AXI_AWADDR == BASE + 32'h04) aw_b_cyc++;
      if (axi.M_AXI_WVALID && axi.M_AXI_AWADDR == BASE + 32'h04) w_b_cyc++;
      if (axi.M_AXI_BREADY && (axi.M_AXI_AWVALID || axi.M_AXI_WVALID)) viol++;
      if (axi.M_AXI_ARVALID && (axi.M_AXI_AWVALID || axi.M_AXI_WVALID || axi.M_AXI_BREADY)) viol++;
      if (axi.M_AXI_RREADY && (axi.M_AXI_AWVALID || axi.M_AXI_WVALID)) viol++;
      if (axi.M_AXI_WVALID && axi.M_AXI_WSTRB != 4'hF) strb_bad++;
    end
  end

  // ---------------- job helpers ----------------
  task automatic start_job(input logic [31:0] a, input logic [31:0] b, input logic sel);
    int unsigned n = 0;
    @(negedge clk);
    while (job_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    chk("job_ready_wait", {31'b0, job_ready}, 32'd1);
    job_valid = 1'b1; job_a = a; job_b = b; job_sel = sel;
    @(negedge clk);
    job_valid = 1'b0; job_a = 32'hFFFF_FFFF; job_b = 32'hFFFF_FFFF; job_sel = ~sel;
  endtask

  task automatic wait_res(output logic [31:0] d, output logic to, output logic er);
    int unsigned n = 0;
    while (res_valid !== 1'b1 && n < 500) begin @(negedge clk); n++; end
    chk("res_wait", {31'b0, res_valid}, 32'd1);
    d = res_data; to = res_timeout; er = res_err;
  endtask

  task automatic consume();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic run_job(input logic [31:0] a, input logic [31:0] b, input logic sel,
                         output logic [31:0] d, output logic to, output logic er);
    start_job(a, b, sel);
    wait_res(d, to, er);
    consume();
  endtask

  // ---------------- directed tests ----------------
  logic [31:0] d;
  logic        to, er;
  int unsigned w0, r0, cnt, hold_bad, awc0, wc0, n;
  logic [31:0] exp_addr[4] = '{BASE, BASE + 32'h04, BASE + 32'h08, BASE + 32'h0C};
  logic [31:0] exp_data[4] = '{32'd2, 32'd3, 32'd0, 32'd1};

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_valids", {27'b0, axi.M_AXI_AWVALID, axi.M_AXI_WVALID, axi.M_AXI_BREADY,
                       axi.M_AXI_ARVALID, axi.M_AXI_RREADY}, 32'd0);
    chk("rst_job_ready", {31'b0, job_ready}, 32'd1);
    chk("rst_busy_resv", {30'b0, busy, res_valid}, 32'd0);
    chk("rst_wstrb", {28'b0, axi.M_AXI_WSTRB}, 32'd0);
    chk("rst_awaddr", axi.M_AXI_AWADDR, 32'd0);
    chk("rst_res_data", res_data, 32'd0);
    rst_n = 1'b1;

    // multiply 2*3, DONE seen on the third poll
    w0 = wr_addr_log.size(); r0 = rd_addr_log.size();
    run_job(32'd2, 32'd3, 1'b0, d, to, er);
    chk("mul_data", d, 32'd6);
    chk("mul_flags", {30'b0, to, er}, 32'd0);
    chk("mul_nwrites", wr_addr_log.size() - w0, 32'd4);
    if (wr_addr_log.size() - w0 == 4)
      for (int i = 0; i < 4; i++) begin
        chk("mul_waddr", wr_addr_log[w0 + i], exp_addr[i]);
        chk("mul_wdata", wr_data_log[w0 + i], exp_data[i]);
      end
    chk("mul_nreads", rd_addr_log.size() - r0, 32'd4);
    chk("mul_last_read", rd_addr_log[rd_addr_log.size() - 1], BASE + 32'h10);

    // exponent 2^3, then a second job offered while RESP is held
    start_job(32'd2, 32'd3, 1'b1);
    wait_res(d, to, er);
    chk("exp_data", d, 32'd8);
    job_valid = 1'b1; job_a = 32'd5; job_b = 32'd7; job_sel = 1'b0;
    hold_bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (res_valid !== 1'b1 || res_data !== 32'd8 || res_timeout !== 1'b0 ||
          res_err !== 1'b0 || job_ready !== 1'b0) hold_bad++;
    end
    chk("hold_stable", hold_bad, 32'd0);
    consume();
    chk("b2b_res_valid_clr", {31'b0, res_valid}, 32'd0);
    chk("b2b_job_ready", {31'b0, job_ready}, 32'd1);
    @(negedge clk);
    job_valid = 1'b0; job_a = '1; job_b = '1;
    chk("b2b_busy", {31'b0, busy}, 32'd1);
    wait_res(d, to, er);
    consume();
    chk("b2b_data", d, 32'd35);

    // AWREADY held off 3 cycles on the B write
    stall_addr = BASE + 32'h04; stall_n = 3;
    awc0 = aw_b_cyc; wc0 = w_b_cyc; w0 = wr_addr_log.size();
    run_job(32'd7, 32'd6, 1'b0, d, to, er);
    stall_addr = 32'hFFFF_FFFF;
    chk("bp_data", d, 32'd42);
    chk("bp_awvalid_cyc", aw_b_cyc - awc0, 32'd4);
    chk("bp_wvalid_cyc", w_b_cyc - wc0, 32'd1);
    cnt = 0;
    for (int unsigned i = w0; i < wr_addr_log.size(); i++)
      if (wr_addr_log[i] == BASE + 32'h04) cnt++;
    chk("bp_b_writes", cnt, 32'd1);

    // DONE never rises: POLL_LIMIT=4 DONE reads, no P read
    done_delay = 1000;
    r0 = rd_addr_log.size();
    run_job(32'd3, 32'd3, 1'b0, d, to, er);
    chk("to_flag", {31'b0, to}, 32'd1);
    chk("to_data", d, 32'd0);
    chk("to_nreads", rd_addr_log.size() - r0, 32'd4);
    cnt = 0;
    for (int unsigned i = r0; i < rd_addr_log.size(); i++)
      if (rd_addr_log[i] == BASE + 32'h14) cnt++;
    chk("to_done_reads", cnt, 32'd4);

    // SLVERR on the SELECT write
    done_delay = 0;
    err_addr = BASE + 32'h08;
    run_job(32'd3, 32'd4, 1'b0, d, to, er);
    err_addr = 32'hFFFF_FFFF;
    chk("err_flag", {31'b0, er}, 32'd1);
    chk("err_data", d, 32'd12);
    chk("err_timeout", {31'b0, to}, 32'd0);

    // asynchronous reset while polling DONE
    done_delay = 1000;
    start_job(32'd9, 32'd9, 1'b0);
    n = 0;
    while (axi.M_AXI_ARVALID !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    chk("rd_done_reached", {31'b0, axi.M_AXI_ARVALID}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valids", {27'b0, axi.M_AXI_AWVALID, axi.M_AXI_WVALID, axi.M_AXI_BREADY,
                        axi.M_AXI_ARVALID, axi.M_AXI_RREADY}, 32'd0);
    chk("arst_busy_resv", {30'b0, busy, res_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_delay = 2;
    run_job(32'd4, 32'd2, 1'b1, d, to, er);
    chk("post_rst_data", d, 32'd16);
    chk("post_rst_flags", {30'b0, to, er}, 32'd0);

    chk("protocol_viol", viol, 32'd0);
    chk("wstrb_bad", strb_bad, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/expmul_job_sequencer.md
Name: expmul_job_sequencer

Overview:
AXI4-Lite master that runs one complete multiply or exponent job on the exponent/multiplier AXI4-Lite slave. It accepts a job (A, B, select) on a valid/ready port and writes A, B, SELECT and START. It then polls DONE with a bounded retry count, reads P, and returns the result on a valid/ready port. It sits between a local requester and the slave, so software-free logic can use the accelerator.

Parameters:
BASE_ADDR, 32'h7C800000, slave base address; register offsets are A 0x00, B 0x04, SELECT 0x08, START 0x0C, P 0x10, DONE 0x14.
POLL_LIMIT, 64, maximum DONE reads before the job is aborted with a timeout (range 1..255).

Ports:
S_AXI_ACLK  in  1  clock
S_AXI_ARESETN  in  1  asynchronous active-low reset
job_valid  in  1  job request
job_ready  out  1  job accepted when job_valid&job_ready
job_a  in  32  operand A
job_b  in  32  operand B
job_sel  in  1  0=multiply, 1=exponent (A^B)
res_valid  out  1  result available
res_ready  in  1  result consumed
res_data  out  32  P value (0 on timeout)
res_timeout  out  1  DONE never seen within POLL_LIMIT reads
res_err  out  1  any BRESP/RRESP != 2'b00 during the job
busy  out  1  high from job accept until the result handshake
M_AXI_AWADDR  out  32;  M_AXI_AWVALID  out  1;  M_AXI_AWREADY  in  1
M_AXI_WDATA  out  32;  M_AXI_WSTRB  out  4;  M_AXI_WVALID  out  1;  M_AXI_WREADY  in  1
M_AXI_BRESP  in  2;  M_AXI_BVALID  in  1;  M_AXI_BREADY  out  1
M_AXI_ARADDR  out  32;  M_AXI_ARVALID  out  1;  M_AXI_ARREADY  in  1
M_AXI_RDATA  in  32;  M_AXI_RRESP  in  2;  M_AXI_RVALID  in  1;  M_AXI_RREADY  out  1

Behaviour:
- Reset values (asynchronous, immediate): state IDLE, all M_AXI_*VALID/READY low, addresses and data 0, WSTRB 0, res_* 0, busy 0, and poll/error registers cleared. Any in-flight job is dropped; the slave is not cleaned up.
- States: IDLE -> WR_A -> WR_B -> WR_SEL -> WR_START -> RD_DONE -> RD_P -> RESP -> IDLE.
- IDLE:
  - job_ready=1 (decoded from the state register).
  - On job_valid, latch job_a, job_b and job_sel, clear err and poll_cnt, set busy, and go to WR_A.
- Write states:
  - Write data: A gets job_a; B gets job_b; SELECT gets {31'b0, job_sel}; START gets 32'd1. WSTRB=4'hF.
  - On state entry, AWVALID and WVALID both rise with AWADDR=BASE_ADDR+offset.
  - Each VALID drops the cycle after its own handshake; the address and data handshakes are tracked independently, so no channel is ever issued twice.
  - Once both handshakes are done, BREADY=1 until BVALID. On that cycle, OR (BRESP!=0) into err and advance.
  - Minimum 2 cycles per write with a zero-wait slave.
- RD_DONE:
  - ARVALID with ARADDR=BASE_ADDR+0x14 until ARREADY; then RREADY=1 until RVALID.
  - On RVALID, OR (RRESP!=0) into err, then:
    - If RDATA[0]=1, go to RD_P.
    - Else increment poll_cnt. If poll_cnt==POLL_LIMIT, go to RESP with timeout=1 and res_data=0; otherwise re-issue the DONE read on the next cycle.
- RD_P: read BASE_ADDR+0x10 the same way; capture RDATA into res_data; OR in RRESP error; go to RESP.
- RESP:
  - res_valid=1, with res_data, res_timeout and res_err stable until res_ready.
  - On res_valid&res_ready, clear res_valid and busy and go to IDLE; job_ready=1 on the following cycle.
- Error responses do not abort the job: the sequence completes and res_err=1.
- No reads and writes overlap: at most one AXI transaction is outstanding.
- job_* changes while busy are ignored.

Test Plan:
- Multiply: job A=2, B=3, sel=0, zero-wait slave -> writes 0x7C800000=2, 0x7C800004=3, 0x7C800008=0, 0x7C80000C=1 in that order; then DONE reads; result res_data=6, timeout=0, err=0.
- Exponent: A=2, B=3, sel=1 -> res_data=8. A back-to-back job A=5, B=7, sel=0, presented while RESP is held, is accepted only after res_ready and returns 35.
- Backpressure: slave holds AWREADY low 3 cycles while WREADY is immediate on the B write -> WVALID high exactly 1 cycle, AWVALID 4 cycles, exactly one B write seen, and BREADY rises only after both handshakes.
- Timeout: POLL_LIMIT=4, DONE stays 0 -> exactly 4 reads of 0x7C800014, no read of 0x7C800010, then res_valid with res_timeout=1 and res_data=0.
- Error response: BRESP=2'b10 on the SELECT write -> sequence continues; the result returns with res_err=1 and the correct res_data.
- Reset and hold:
  - S_AXI_ARESETN low mid RD_DONE -> all VALIDs, busy and res_valid go 0 immediately.
  - After release, a new job A=4, B=2, sel=1 returns 16.
  - res_ready held low 5 cycles -> res_* stable and job_ready=0 throughout.
